// File: rtl/bcd_serial_alu.sv
// Digit-serial packed-BCD ALU: decimal add, sign/magnitude subtract and digit shifts,
// one BCD digit per clock, behind valid/ready request and result ports.
module bcd_serial_alu #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [4*DIGITS-1:0]   operand_a,
  input  logic [4*DIGITS-1:0]   operand_b,
  output logic [4*DIGITS-1:0]   result,
  output logic                  flag,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic           carry_q, carry_d;
  logic           acc_q, acc_d;
  logic           bad_q, bad_d;
  logic           shen_q, shen_d;
  logic [CW-1:0]  cnt_q, cnt_d, last_q, last_d;
  logic           in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic [W-1:0]   result_q, result_d;
  logic           flag_q, flag_d, err_q, err_d;

  // Digit adder shared by the RUN and FIX passes
  logic [3:0]     add_x, add_y, dig;
  logic [4:0]     sum;
  logic           cout;
  logic [CW-1:0]  n_c;
  logic           is_shift_c;

  // True if any of the lowest nd digits of v is not a BCD digit
  function automatic logic nib_bad(input logic [W-1:0] v, input int unsigned nd);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i < nd && v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Decimal digit add with >9 correction; FIX pass adds the 9's complement of the result digit
  always_comb begin
    add_x = (state_q == FIX) ? 4'(4'd9 - res_q[3:0]) : a_q[3:0];
    add_y = (state_q == FIX) ? 4'd0 :
            (op_q == OP_SUB) ? 4'(4'd9 - b_q[3:0]) : b_q[3:0];
    sum   = 5'(add_x) + 5'(add_y) + 5'(carry_q);
    cout  = (sum > 5'd9);
    dig   = cout ? 4'(sum - 5'd10) : sum[3:0];
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    carry_d    = carry_q;
    acc_d      = acc_q;
    bad_d      = bad_q;
    shen_d     = shen_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    result_d   = result_q;
    flag_d     = flag_q;
    err_d      = err_q;
    is_shift_c = (op[2:1] == 2'b01);
    n_c        = (32'(operand_b[3:0]) >= DIGITS) ? CW'(DIGITS) : CW'(operand_b[3:0]);

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          op_d    = op[1:0];
          a_d     = operand_a;
          b_d     = operand_b;
          cnt_d   = '0;
          carry_d = (op == 3'b001);
          acc_d   = 1'b0;
          if (is_shift_c) begin
            bad_d  = nib_bad(operand_a, 1) | nib_bad(operand_b, 1);
            res_d  = operand_a;
            shen_d = (n_c != '0);
            last_d = (n_c == '0) ? '0 : CW'(n_c - CW'(1));
          end else begin
            bad_d  = op[2] | nib_bad(operand_a, DIGITS) | nib_bad(operand_b, DIGITS);
            res_d  = '0;
            shen_d = 1'b0;
            last_d = CW'(DIGITS - 1);
          end
          state_d = RUN;
        end
      end

      RUN: begin
        if (bad_q) begin
          result_d = '0;
          flag_d   = 1'b0;
          err_d    = 1'b1;
          state_d  = DONE;
        end else if (op_q[1]) begin
          // Digit shift, zero fill, remember any nonzero digit pushed out
          if (shen_q) begin
            if (op_q == OP_SHL) begin
              res_d = res_q << 4;
              acc_d = acc_q | (res_q[W-1 -: 4] != 4'd0);
            end else begin
              res_d = res_q >> 4;
              acc_d = acc_q | (res_q[3:0] != 4'd0);
            end
          end
          cnt_d = CW'(cnt_q + CW'(1));
          if (cnt_q == last_q) begin
            result_d = res_d;
            flag_d   = acc_d;
            err_d    = 1'b0;
            state_d  = DONE;
          end
        end else begin
          a_d     = a_q >> 4;
          b_d     = b_q >> 4;
          res_d   = (res_q >> 4) | (W'(dig) << (W - 4));
          carry_d = cout;
          cnt_d   = CW'(cnt_q + CW'(1));
          if (cnt_q == last_q) begin
            if (op_q == OP_ADD || cout) begin
              result_d = res_d;
              flag_d   = (op_q == OP_ADD) ? cout : 1'b0;
              err_d    = 1'b0;
              state_d  = DONE;
            end else begin
              // Negative difference: re-complement to recover the magnitude
              cnt_d   = '0;
              carry_d = 1'b1;
              state_d = FIX;
            end
          end
        end
      end

      FIX: begin
        res_d   = (res_q >> 4) | (W'(dig) << (W - 4));
        carry_d = cout;
        cnt_d   = CW'(cnt_q + CW'(1));
        if (cnt_q == last_q) begin
          result_d = res_d;
          flag_d   = 1'b1;
          err_d    = 1'b0;
          state_d  = DONE;
        end
      end

      DONE: begin
        if (out_valid_q && out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      acc_q       <= 1'b0;
      bad_q       <= 1'b0;
      shen_q      <= 1'b0;
      cnt_q       <= '0;
      last_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      flag_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      acc_q       <= acc_d;
      bad_q       <= bad_d;
      shen_q      <= shen_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
      flag_q      <= flag_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign flag      = flag_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Directed bench for bcd_serial_alu with DIGITS = 4.
module tb_bcd_serial_alu;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] operand_a, operand_b, result;
  logic         flag, err, out_valid, out_ready, busy;

  always #5 clk = ~clk;

  bcd_serial_alu #(.DIGITS(DIGITS)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand_a(operand_a), .operand_b(operand_b), .result(result),
    .flag(flag), .err(err), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         flag;
    logic         err;
    int           lat;
  } vec_t;

  localparam int NV = 17;
  vec_t vt[NV];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, scramble the operands after accept, measure latency and check the result
  task automatic run_vec(input int id, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic f, input logic e, input int lat);
    int cyc;
    check($sformatf("v%0d in_ready", id), 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'b111; operand_a = '1; operand_b = '1;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("v%0d latency", id), 32'(cyc), 32'(lat));
    check($sformatf("v%0d result", id), 32'(result), 32'(res));
    check($sformatf("v%0d flag", id), 32'(flag), 32'(f));
    check($sformatf("v%0d err", id), 32'(err), 32'(e));
    if (out_valid) begin
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid drop", id), 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    int cyc;
    logic saw;
    vt[0]  = '{3'b000, 16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0, 4};
    vt[1]  = '{3'b000, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 4};
    vt[2]  = '{3'b001, 16'h0500, 16'h0500, 16'h0000, 1'b0, 1'b0, 4};
    vt[3]  = '{3'b001, 16'h0100, 16'h0250, 16'h0150, 1'b1, 1'b0, 8};
    vt[4]  = '{3'b001, 16'h0250, 16'h0100, 16'h0150, 1'b0, 1'b0, 4};
    vt[5]  = '{3'b010, 16'h1234, 16'h0002, 16'h3400, 1'b1, 1'b0, 2};
    vt[6]  = '{3'b011, 16'h1200, 16'h0002, 16'h0012, 1'b0, 1'b0, 2};
    vt[7]  = '{3'b010, 16'h1234, 16'h0009, 16'h0000, 1'b1, 1'b0, 4};
    vt[8]  = '{3'b010, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1};
    vt[9]  = '{3'b000, 16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 1};
    vt[10] = '{3'b111, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b1, 1};
    vt[11] = '{3'b000, 16'h4567, 16'h5678, 16'h0245, 1'b1, 1'b0, 4};
    vt[12] = '{3'b001, 16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 8};
    vt[13] = '{3'b011, 16'h1234, 16'h0001, 16'h0123, 1'b1, 1'b0, 1};
    vt[14] = '{3'b010, 16'h1234, 16'hFF03, 16'h4000, 1'b1, 1'b0, 3};
    vt[15] = '{3'b011, 16'h1234, 16'h000A, 16'h0000, 1'b0, 1'b1, 1};
    vt[16] = '{3'b001, 16'h1234, 16'h0A00, 16'h0000, 1'b0, 1'b1, 1};

    reset_n = 1'b0; in_valid = 1'b0; op = 3'b000; operand_a = '0; operand_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset flag", 32'(flag), 32'd0);
    check("reset err", 32'(err), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++)
      run_vec(i, vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].flag, vt[i].err, vt[i].lat);

    // Back-pressure: result held while out_ready is low, request pulse ignored
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'b000; operand_a = 16'h0999; operand_b = 16'h0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("hold latency", 32'(cyc), 32'd4);
    for (int k = 0; k < 5; k++) begin
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold result", 32'(result), 32'h1000);
      check("hold in_ready", 32'(in_ready), 32'd0);
      check("hold busy", 32'(busy), 32'd1);
      in_valid = (k == 2); op = 3'b000; operand_a = 16'h0001; operand_b = 16'h0001;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release out_valid", 32'(out_valid), 32'd0);
    check("release in_ready", 32'(in_ready), 32'd1);
    saw = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      saw = saw | out_valid | busy;
    end
    check("ignored pulse", 32'(saw), 32'd0);

    // Asynchronous reset two cycles into a negative subtract
    in_valid = 1'b1; op = 3'b001; operand_a = 16'h0100; operand_b = 16'h0250;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("async rst in_ready", 32'(in_ready), 32'd1);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst result", 32'(result), 32'd0);
    check("async rst flag", 32'(flag), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      saw = saw | out_valid;
    end
    check("no result after abort", 32'(saw), 32'd0);
    run_vec(100, 3'b000, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_serial_alu.md
Name: bcd_serial_alu

Overview:
- Parametrised, digit-serial packed-BCD ALU.
- Operates directly on DIGITS-digit BCD operands, one digit per clock, with no binary round-trip.
- Provides decimal add, 10's-complement subtract with sign/magnitude result, and decimal digit shifts.
- Sits behind a valid/ready request port and a valid/ready result port, feeding the decimal datapath.

Parameters:
- DIGITS, 4, number of BCD digits per operand/result (legal 1..16); data width W = 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- op  input  3  000 ADD, 001 SUB, 010 SHL, 011 SHR, others illegal
- operand_a  input  W  packed BCD, digit 0 in bits [3:0]
- operand_b  input  W  packed BCD; for shifts only digit 0 is used as the shift count
- result  output  W  packed BCD result
- flag  output  1  ADD: carry out; SUB: result negative; SHL/SHR: a nonzero digit was shifted out
- err  output  1  illegal op or non-BCD nibble (>9) in a used operand digit
- out_valid  output  1  result/flag/err valid
- out_ready  input  1  consumer accepts the result
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (reset_n).
- Reset values: all outputs 0 except in_ready = 1; state = IDLE; internal registers 0.
- Reset asserted mid-operation aborts the operation immediately; no partial result is ever presented.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - in_ready = 1.
  - Accept on in_valid & in_ready: latch op, A, B; clear counter; carry = 1 for SUB, else 0.
  - Validation at accept:
    - ADD/SUB check all digits of A and B; SHL/SHR check A and B digit 0.
    - Illegal op or invalid digit: result = 0, err = 1, flag = 0, go to DONE (out_valid 1 cycle after accept).
- RUN, ADD/SUB, one digit per cycle, LSD first:
  - bd = B digit for ADD, 9 - B digit for SUB.
  - s = A digit + bd + carry.
  - If s > 9: digit = s - 10, carry = 1; else digit = s, carry = 0.
  - A and B shift right 4 each cycle; the result digit enters at the top of the result shift register.
  - After DIGITS cycles:
    - ADD: flag = carry, go to DONE.
    - SUB with final carry = 1: non-negative, flag = 0, go to DONE.
    - SUB with final carry = 0: negative, flag = 1, go to FIX.
- FIX (SUB negative only):
  - Second serial pass over DIGITS cycles: digit = 9 - r digit + c, c initialised to 1, same >9 correction.
  - Produces the magnitude |A - B|, then go to DONE.
- RUN, SHL/SHR:
  - n = min(B digit 0, DIGITS).
  - Each cycle shifts the result one digit (SHL toward MSD, SHR toward LSD), zero-filling.
  - flag is set if any discarded digit != 0.
  - n cycles; n = 0 takes one cycle with result = A, flag = 0.
- Latency from the accept edge to out_valid high:
  - ADD: DIGITS cycles.
  - SUB: DIGITS cycles if non-negative, 2*DIGITS if negative.
  - Shift: max(n, 1) cycles.
  - Error: 1 cycle.
- DONE:
  - out_valid = 1; result/flag/err stable until out_valid & out_ready.
  - On that edge: out_valid = 0, go to IDLE.
  - in_ready stays 0 in DONE; no new accept occurs in the same cycle as result handoff.
- in_valid while busy is ignored; there is no queuing.
- Operand changes after accept have no effect.
- Result is modulo 10^DIGITS; ADD overflow is reported only via flag.
- SUB of equal operands: result 0, flag = 0.

Test Plan:
- DIGITS=4, ADD 0999 + 0001, out_ready = 1 -> result 1000, flag 0, err 0, out_valid exactly 4 cycles after accept, for 1 cycle.
- ADD 9999 + 0001 -> result 0000, flag 1; SUB 0500 - 0500 -> 0000, flag 0, latency 4.
- SUB 0100 - 0250 -> result 0150, flag 1, latency 8; SUB 0250 - 0100 -> 0150, flag 0, latency 4.
- SHL A=1234, B=0002 -> 3400, flag 1, latency 2; SHR 1200 by 2 -> 0012, flag 0; SHL by 0009 -> clamped n = 4, result 0000, flag 1, latency 4; SHL by 0000 -> 1234, flag 0, latency 1.
- ADD 12A4 + 0001 -> result 0, err 1, latency 1; op = 111 -> err 1. Hold out_ready = 0 for 5 cycles -> outputs stable, in_ready 0, a pulsed in_valid is ignored; release -> single handoff, then back to IDLE.
- reset_n low 2 cycles into a SUB -> all outputs 0 and in_ready 1 immediately (asynchronous); no out_valid follows; a new ADD 0001 + 0002 afterwards -> 0003.
